// File: rtl/z80_mem_store_seq.sv
// z80_mem_store_seq: T-state sequencer for byte, indexed and word memory stores with wait/timeout handling.
// Optional trace outputs for the z80fi checkers are enabled by defining Z80FI_STORE_TRACE_EN.
module z80_mem_store_seq #(
  parameter int ADDR_W = 16,
  parameter int WAIT_LIMIT = 0,
  parameter int CALC_T = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        disp,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_wr,
  input  logic              bus_wait
`ifdef Z80FI_STORE_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [7:0]        trace_tcycles1,
  output logic [7:0]        trace_tcycles2,
  output logic [7:0]        trace_tcycles3,
  output logic [ADDR_W-1:0] trace_waddr,
  output logic [7:0]        trace_wdata
`endif
);
  localparam int WC_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam int CC_W = (CALC_T > 1) ? $clog2(CALC_T) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam logic [CC_W-1:0] CALC_LAST = CC_W'(CALC_T - 1);
  localparam logic [WC_W-1:0] WAIT_INC = WC_W'(WAIT_LIMIT > 0);
  typedef enum logic [2:0] {IDLE, CALC, W_T1, W_T2, W_TW, W_T3, DONE} state_t;
  state_t            state;
  logic [1:0]        op_mode;
  logic [ADDR_W-1:0] op_base;
  logic [7:0]        op_disp;
  logic [15:0]       op_wdata;
  logic              second;
  logic [CC_W-1:0]   calc_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0] ea;
  logic              timeout;
  always_comb begin
    ea = op_base + {{(ADDR_W-8){op_disp[7]}}, op_disp};
    timeout = (WAIT_LIMIT > 0) && bus_wait && (wait_cnt == WAIT_LAST);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_mode   <= '0;
      op_base   <= '0;
      op_disp   <= '0;
      op_wdata  <= '0;
      second    <= 1'b0;
      calc_cnt  <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_mode  <= mode;
          op_base  <= base_addr;
          op_disp  <= disp;
          op_wdata <= wdata;
          second   <= 1'b0;
          calc_cnt <= '0;
          wait_cnt <= '0;
          // reserved mode completes immediately, so busy never rises
          if (mode == 2'd3) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            busy  <= 1'b1;
            state <= (mode == 2'd1) ? CALC : W_T1;
            if (mode != 2'd1) begin
              bus_addr  <= base_addr;
              bus_wdata <= wdata[7:0];
            end
          end
        end
        CALC: if (calc_cnt == CALC_LAST) begin
          state     <= W_T1;
          bus_addr  <= ea;
          bus_wdata <= op_wdata[7:0];
        end else calc_cnt <= calc_cnt + 1'b1;
        W_T1: begin
          bus_wr <= 1'b1;
          state  <= W_T2;
        end
        W_T2: state <= bus_wait ? W_TW : W_T3;
        W_TW: if (timeout) begin
          bus_wr <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          err    <= 1'b1;
          state  <= DONE;
        end else if (bus_wait) wait_cnt <= wait_cnt + WAIT_INC;
        else state <= W_T3;
        W_T3: begin
          bus_wr <= 1'b0;
          if (op_mode == 2'd2 && !second) begin
            second    <= 1'b1;
            wait_cnt  <= '0;
            bus_addr  <= op_base + ADDR_W'(1);
            bus_wdata <= op_wdata[15:8];
            state     <= W_T1;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef Z80FI_STORE_TRACE_EN
  assign trace_valid = done;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_tcycles1 <= '0;
      trace_tcycles2 <= '0;
      trace_tcycles3 <= '0;
      trace_waddr    <= '0;
      trace_wdata    <= '0;
    end else begin
      if (state == IDLE && start) begin
        trace_tcycles1 <= '0;
        trace_tcycles2 <= '0;
        trace_tcycles3 <= '0;
      end else if (state == CALC) trace_tcycles1 <= trace_tcycles1 + {7'd0, ~&trace_tcycles1};
      else if (state inside {W_T1, W_T2, W_TW, W_T3}) begin
        if (second) trace_tcycles3 <= trace_tcycles3 + {7'd0, ~&trace_tcycles3};
        else trace_tcycles2 <= trace_tcycles2 + {7'd0, ~&trace_tcycles2};
      end
      if (state == W_T3) begin
        trace_waddr <= bus_addr;
        trace_wdata <= bus_wdata;
      end
    end
  end
`endif
endmodule

// File: tb/tb_z80_mem_store_seq.sv
// tb_z80_mem_store_seq: directed bench with a cycle-level expectation model for unlimited and 2-state wait limits.
module tb_z80_mem_store_seq;
  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic wr;
    logic [15:0] addr;
    logic [7:0] data;
  } obs_t;
  localparam int CALC_T = 5;
  logic clk = 0, reset = 0, start = 0, bus_wait = 0;
  logic [1:0] mode = 0;
  logic [15:0] base_addr = 0, wdata = 0;
  logic [7:0] disp = 0;
  logic [1:0] busy_o, done_o, err_o, wr_o;
  logic [15:0] addr_o [2];
  logic [7:0] data_o [2];
`ifdef Z80FI_STORE_TRACE_EN
  logic [1:0] tv_o;
  logic [7:0] tc1_o [2], tc2_o [2], tc3_o [2], twd_o [2];
  logic [15:0] twa_o [2];
`endif
  int checks = 0, errors = 0, cyc = 0;
  obs_t ex [2][4096];
  obs_t act [2][4096];
  bit ev [2][4096];
  logic [15:0] m_addr [2], m_waddr [2];
  logic [7:0] m_data [2], m_wdata [2];
  logic [7:0] m_tc [2][3];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    z80_mem_store_seq #(.ADDR_W(16), .WAIT_LIMIT(g * 2), .CALC_T(CALC_T)) u (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
      .disp(disp), .wdata(wdata), .busy(busy_o[g]), .done(done_o[g]), .err(err_o[g]),
      .bus_addr(addr_o[g]), .bus_wdata(data_o[g]), .bus_wr(wr_o[g]), .bus_wait(bus_wait)
`ifdef Z80FI_STORE_TRACE_EN
      , .trace_valid(tv_o[g]), .trace_tcycles1(tc1_o[g]), .trace_tcycles2(tc2_o[g]),
      .trace_tcycles3(tc3_o[g]), .trace_waddr(twa_o[g]), .trace_wdata(twd_o[g])
`endif
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic emit(input int d, input int c, input logic b, input logic dn, input logic er, input logic wr);
    ex[d][c] = '{b, dn, er, wr, m_addr[d], m_data[d]};
    ev[d][c] = 1'b1;
  endtask

  // Expected per-cycle outputs for one operation starting in cycle s; wv[k] is bus_wait in cycle s+k.
  task automatic model(input int d, input int lim, input int s, input logic [1:0] md, input logic [15:0] ba,
                       input logic [7:0] dp, input logic [15:0] wd, input logic [31:0] wv, output int last);
    logic [15:0] wa [$];
    logic [7:0] wdq [$];
    bit er, w;
    int k, n, tw;
    k = s;
    er = (md == 2'd3);
    emit(d, k, 0, 0, 0, 0); k++;
    for (int i = 0; i < 3; i++) m_tc[d][i] = 8'd0;
    if (md == 2'd1) begin
      for (int i = 0; i < CALC_T; i++) begin emit(d, k, 1, 0, 0, 0); k++; end
      m_tc[d][0] = 8'(CALC_T);
      wa.push_back(ba + {{8{dp[7]}}, dp});
      wdq.push_back(wd[7:0]);
    end
    if (md == 2'd0 || md == 2'd2) begin wa.push_back(ba); wdq.push_back(wd[7:0]); end
    if (md == 2'd2) begin wa.push_back(ba + 16'd1); wdq.push_back(wd[15:8]); end
    for (int i = 0; i < wa.size() && !er; i++) begin
      m_addr[d] = wa[i];
      m_data[d] = wdq[i];
      emit(d, k, 1, 0, 0, 0); k++;
      emit(d, k, 1, 0, 0, 1); w = (k - s < 32) ? wv[k - s] : 1'b0; k++;
      n = 2;
      tw = 0;
      while (w) begin
        emit(d, k, 1, 0, 0, 1); w = (k - s < 32) ? wv[k - s] : 1'b0; k++;
        n++;
        tw++;
        if (w && lim > 0 && tw >= lim) begin er = 1; w = 0; end
      end
      if (!er) begin
        emit(d, k, 1, 0, 0, 1); k++;
        n++;
        m_waddr[d] = wa[i];
        m_wdata[d] = wdq[i];
      end
      m_tc[d][i + 1] = (n > 255) ? 8'd255 : 8'(n);
    end
    emit(d, k, 0, 1, er, 0);
    last = k;
  endtask

  task automatic run_op(input logic [1:0] md, input logic [15:0] ba, input logic [7:0] dp, input logic [15:0] wd,
                        input logic [31:0] wv, input bit hold, output int s);
    int l0, l1, n;
    @(posedge clk); #1;
    s = cyc;
    start = 1; mode = md; base_addr = ba; disp = dp; wdata = wd; bus_wait = wv[0];
    model(0, 0, s, md, ba, dp, wd, wv, l0);
    model(1, 2, s, md, ba, dp, wd, wv, l1);
    n = ((l0 > l1) ? l0 : l1) - s + 2;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      start = hold && k == 1;
      if (hold && k == 1) base_addr = ~ba;
      bus_wait = (k < 32) ? wv[k] : 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (cyc < 4096) begin
      for (int d = 0; d < 2; d++) begin
        act[d][cyc] = '{busy_o[d], done_o[d], err_o[d], wr_o[d], addr_o[d], data_o[d]};
        if (ev[d][cyc]) begin
          chk($sformatf("dut%0d cyc%0d outputs", d, cyc), 32'(act[d][cyc]), 32'(ex[d][cyc]));
`ifdef Z80FI_STORE_TRACE_EN
          if (ex[d][cyc].done) begin
            chk($sformatf("dut%0d cyc%0d trace counts", d, cyc),
                32'({tv_o[d], tc1_o[d], tc2_o[d], tc3_o[d]}), 32'({1'b1, m_tc[d][0], m_tc[d][1], m_tc[d][2]}));
            chk($sformatf("dut%0d cyc%0d trace last", d, cyc),
                32'({twa_o[d], twd_o[d]}), 32'({m_waddr[d], m_wdata[d]}));
          end
`endif
        end
      end
    end
  end

  initial begin
    int s;
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 0; m_data[d] = 0; m_waddr[d] = 0; m_wdata[d] = 0;
    end
    #1 reset = 1;
    #2;
    chk("reset ctrl", 32'({busy_o, done_o, err_o, wr_o}), 32'h0);
    chk("reset bus0", 32'({addr_o[0], data_o[0]}), 32'h0);
    chk("reset bus1", 32'({addr_o[1], data_o[1]}), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    run_op(2'd0, 16'h1234, 8'h00, 16'h00A5, 32'h0, 0, s);
    chk("m0 T1 wr", 32'(act[0][s+1].wr), 32'h0);
    chk("m0 T2 bus", 32'({act[0][s+2].wr, act[0][s+2].addr, act[0][s+2].data}), 32'h1_1234_A5);
    chk("m0 T3 wr", 32'(act[0][s+3].wr), 32'h1);
    chk("m0 done", 32'({act[0][s+4].done, act[0][s+4].err, act[0][s+4].wr}), 32'b100);
    run_op(2'd1, 16'hFFF0, 8'h20, 16'h0011, 32'h0, 0, s);
    chk("m1 calc hold", 32'({act[0][s+5].wr, act[0][s+5].addr}), 32'h0_1234);
    chk("m1 wrap addr", 32'(act[0][s+6].addr), 32'h0010);
    chk("m1 done clk9", 32'(act[0][s+9].done), 32'h1);
`ifdef Z80FI_STORE_TRACE_EN
    chk("m1 tcycles", 32'({tc1_o[0], tc2_o[0], tc3_o[0]}), 32'h05_03_00);
`endif
    run_op(2'd1, 16'h8000, 8'hFE, 16'h0022, 32'h0, 1, s);
    chk("m1 neg disp", 32'(act[0][s+6].addr), 32'h7FFE);
    run_op(2'd2, 16'hFFFF, 8'h00, 16'hBEEF, 32'h0, 0, s);
    chk("m2 lo write", 32'({act[0][s+1].addr, act[0][s+1].data}), 32'hFFFF_EF);
    chk("m2 hi write", 32'({act[0][s+4].addr, act[0][s+4].data}), 32'h0000_BE);
    chk("m2 done", 32'(act[0][s+7].done), 32'h1);
    run_op(2'd0, 16'h2000, 8'h00, 16'h005A, 32'h3C, 0, s);
    chk("wait wr held", 32'(act[0][s+6].wr), 32'h1);
    chk("wait done", 32'({act[0][s+8].done, act[0][s+8].err}), 32'b10);
    chk("lim2 short timeout", 32'({act[1][s+5].done, act[1][s+5].err, act[1][s+5].wr}), 32'b110);
`ifdef Z80FI_STORE_TRACE_EN
    chk("wait tcycles2", 32'(tc2_o[0]), 32'h7);
`endif
    run_op(2'd2, 16'h3000, 8'h00, 16'h1122, 32'hFFFF_FFFF, 0, s);
    chk("lim2 stuck abort", 32'({act[1][s+5].done, act[1][s+5].err, act[1][s+5].wr}), 32'b110);
    chk("lim2 no 2nd write", 32'({act[1][s+6].wr, act[1][s+7].wr}), 32'h0);
`ifdef Z80FI_STORE_TRACE_EN
    chk("lim2 tcycles3", 32'(tc3_o[1]), 32'h0);
`endif
    run_op(2'd3, 16'h5555, 8'h00, 16'h0000, 32'h0, 0, s);
    chk("m3 dut0", 32'({act[0][s+1].busy, act[0][s+1].done, act[0][s+1].err, act[0][s+1].wr}), 32'b0110);
    chk("m3 dut1", 32'({act[1][s+1].busy, act[1][s+1].done, act[1][s+1].err, act[1][s+1].wr}), 32'b0110);
    @(posedge clk); #1;
    start = 1; mode = 2'd0; base_addr = 16'h4444; wdata = 16'h0077; bus_wait = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre-reset wr", 32'(wr_o), 32'h3);
    reset = 1;
    #1;
    chk("async reset wr", 32'(wr_o), 32'h0);
    chk("async reset busy", 32'(busy_o), 32'h0);
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 0; m_data[d] = 0; m_waddr[d] = 0; m_wdata[d] = 0;
    end
    @(posedge clk); #1;
    reset = 0; bus_wait = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no done after reset", 32'(done_o), 32'h0);
    end
    run_op(2'd0, 16'h00FF, 8'h00, 16'h0033, 32'h0, 0, s);
    chk("post-reset write", 32'({act[1][s+2].wr, act[1][s+2].addr, act[1][s+2].data}), 32'h1_00FF_33);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
